// File: rtl/fire_ctrl_pkg.sv
// Shared types and default timing constants for the fire-control stage.
package fire_ctrl_pkg;

  typedef enum logic [2:0] {
    StSafe     = 3'd0,
    StArmed    = 3'd1,
    StFire     = 3'd2,
    StCharging = 3'd3,
    StCooldown = 3'd4,
    StFault    = 3'd5
  } state_t;

  localparam int unsigned DefDebounceCycles = 100000;
  localparam int unsigned DefChargeTimeout  = 150000000;
  localparam int unsigned DefCooldownCycles = 200000000;
  localparam int unsigned DefCntW           = 32;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, hold-time debouncer and one-cycle press strobe for a raw pushbutton.
module btn_debounce
  import fire_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q, press_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        // Accept the new level; strobe only on a 0->1 flip.
        cnt_q   <= '0;
        level_q <= sync2_q;
        press_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/fire_ctrl.sv
// Safe/armed/fire/charging/cooldown/fault controller driving the coil trigger from debounced buttons.
module fire_ctrl
  import fire_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned CHARGE_TIMEOUT  = DefChargeTimeout,
  parameter int unsigned COOLDOWN_CYCLES = DefCooldownCycles,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm_btn,
  input  logic       fire_btn,
  input  logic       charge_busy,
  output logic       fire_pulse,
  output logic       armed,
  output logic       cooldown,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] ChargeLast = CNT_W'(CHARGE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CoolLast   = CNT_W'(COOLDOWN_CYCLES - 1);

  logic arm_level, arm_strobe, fire_level, fire_strobe;
  logic arm_press, fire_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_arm_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (arm_btn),
    .level (arm_level),
    .press (arm_strobe)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_fire_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (fire_btn),
    .level (fire_level),
    .press (fire_strobe)
  );

  // A press only counts while its debounced level is actually high.
  assign arm_press  = arm_strobe & arm_level;
  assign fire_press = fire_strobe & fire_level;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             seen_q, seen_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    seen_d  = seen_q;
    case (state_q)
      StSafe: begin
        if (arm_press) state_d = StArmed;
      end
      StArmed: begin
        if (arm_press)       state_d = StSafe;
        else if (fire_press) state_d = StFire;
      end
      StFire: begin
        state_d = StCharging;
        timer_d = '0;
        seen_d  = 1'b0;
      end
      StCharging: begin
        timer_d = timer_q + 1'b1;
        if (charge_busy) seen_d = 1'b1;
        // Completion takes priority over timeout in the same cycle.
        if (seen_q && !charge_busy) begin
          state_d = StCooldown;
          timer_d = '0;
        end else if (timer_q == ChargeLast) begin
          state_d = StFault;
          timer_d = '0;
        end
      end
      StCooldown: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == CoolLast) begin
          state_d = StSafe;
          timer_d = '0;
        end
      end
      StFault: begin
        if (arm_press) state_d = StSafe;
      end
      default: state_d = StSafe;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StSafe;
      timer_q    <= '0;
      seen_q     <= 1'b0;
      fire_pulse <= 1'b0;
      armed      <= 1'b0;
      cooldown   <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      seen_q     <= seen_d;
      fire_pulse <= (state_d == StFire);
      armed      <= (state_d == StArmed);
      cooldown   <= (state_d == StCooldown);
      fault      <= (state_d == StFault);
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_fire_ctrl.sv
// Directed bench for fire_ctrl with short debounce/timeout/cooldown settings.
module tb_fire_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm_btn, fire_btn, charge_busy;
  logic       fire_pulse, armed, cooldown, fault;
  logic [2:0] state_o;

  int n_cmp   = 0;
  int n_err   = 0;
  int n_pulse = 0;
  int p0;
  logic saw_armed;

  fire_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CHARGE_TIMEOUT  (20),
    .COOLDOWN_CYCLES (10),
    .CNT_W           (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm_btn     (arm_btn),
    .fire_btn    (fire_btn),
    .charge_busy (charge_busy),
    .fire_pulse  (fire_pulse),
    .armed       (armed),
    .cooldown    (cooldown),
    .fault       (fault),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (fire_pulse) n_pulse++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press the selected buttons, hold through debounce, then release and let the release settle.
  task automatic tap(input logic a, input logic f);
    if (a) arm_btn = 1'b1;
    if (f) fire_btn = 1'b1;
    repeat (7) tick();
    if (a) arm_btn = 1'b0;
    if (f) fire_btn = 1'b0;
    repeat (7) tick();
  endtask

  initial begin
    rst = 1'b1;
    arm_btn = 1'b0;
    fire_btn = 1'b0;
    charge_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_state", 32'(state_o), 0);
    check_eq("rst_pulse", 32'(fire_pulse), 0);
    check_eq("rst_armed", 32'(armed), 0);
    check_eq("rst_cool", 32'(cooldown), 0);
    check_eq("rst_fault", 32'(fault), 0);

    // 1. Bounce rejection then a clean hold.
    saw_armed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      arm_btn = 1'b1;
      tick(); saw_armed |= armed;
      tick(); saw_armed |= armed;
      arm_btn = 1'b0;
      tick(); saw_armed |= armed;
      tick(); saw_armed |= armed;
    end
    check_eq("bounce_armed", 32'(saw_armed), 0);
    arm_btn = 1'b1;
    repeat (6) tick();
    check_eq("hold6_armed", 32'(armed), 0);
    tick();
    check_eq("hold7_armed", 32'(armed), 1);
    check_eq("hold7_state", 32'(state_o), 1);
    arm_btn = 1'b0;
    repeat (7) tick();

    // 2. Normal shot.
    fire_btn = 1'b1;
    repeat (7) tick();
    check_eq("shot_fire_state", 32'(state_o), 2);
    check_eq("shot_pulse_hi", 32'(fire_pulse), 1);
    tick();
    check_eq("shot_chg_state", 32'(state_o), 3);
    check_eq("shot_pulse_lo", 32'(fire_pulse), 0);
    fire_btn = 1'b0;
    charge_busy = 1'b1;
    repeat (5) tick();
    check_eq("shot_busy_state", 32'(state_o), 3);
    charge_busy = 1'b0;
    tick();
    check_eq("shot_cool_state", 32'(state_o), 4);
    check_eq("shot_cool_out", 32'(cooldown), 1);
    repeat (9) tick();
    check_eq("shot_cool9", 32'(cooldown), 1);
    tick();
    check_eq("shot_safe_state", 32'(state_o), 0);
    check_eq("shot_safe_cool", 32'(cooldown), 0);
    check_eq("shot_safe_armed", 32'(armed), 0);
    check_eq("shot_pulses", n_pulse, 1);

    // 3. Charge timeout into sticky fault.
    tap(1'b1, 1'b0);
    check_eq("to_armed", 32'(state_o), 1);
    fire_btn = 1'b1;
    repeat (8) tick();
    check_eq("to_chg", 32'(state_o), 3);
    fire_btn = 1'b0;
    repeat (19) tick();
    check_eq("to_19_fault", 32'(fault), 0);
    tick();
    check_eq("to_20_fault", 32'(fault), 1);
    check_eq("to_20_state", 32'(state_o), 5);
    p0 = n_pulse;
    tap(1'b0, 1'b1);
    check_eq("fault_fire_state", 32'(state_o), 5);
    check_eq("fault_fire_pulses", n_pulse, p0);
    tap(1'b1, 1'b0);
    check_eq("fault_clear_state", 32'(state_o), 0);
    check_eq("fault_clear_out", 32'(fault), 0);

    // 4. Simultaneous arm and fire in ARMED: arm wins.
    tap(1'b1, 1'b0);
    p0 = n_pulse;
    tap(1'b1, 1'b1);
    check_eq("simul_state", 32'(state_o), 0);
    check_eq("simul_pulses", n_pulse, p0);

    // 5. Held fire across a shot and re-arm.
    p0 = n_pulse;
    tap(1'b1, 1'b0);
    fire_btn = 1'b1;
    repeat (8) tick();
    charge_busy = 1'b1;
    repeat (2) tick();
    charge_busy = 1'b0;
    tick();
    check_eq("held_cool", 32'(state_o), 4);
    repeat (10) tick();
    check_eq("held_safe", 32'(state_o), 0);
    tap(1'b1, 1'b0);
    repeat (10) tick();
    check_eq("held_rearm_state", 32'(state_o), 1);
    check_eq("held_pulses", n_pulse, p0 + 1);
    fire_btn = 1'b0;
    repeat (7) tick();
    check_eq("held_release_state", 32'(state_o), 1);
    fire_btn = 1'b1;
    repeat (7) tick();
    check_eq("repress_pulse", 32'(fire_pulse), 1);
    check_eq("repress_state", 32'(state_o), 2);

    // 6. Async reset during FIRE, then during COOLDOWN at count 5.
    #2 rst = 1'b1;
    #1;
    check_eq("arst_fire_state", 32'(state_o), 0);
    check_eq("arst_fire_pulse", 32'(fire_pulse), 0);
    fire_btn = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_eq("arst_fire_count", n_pulse, p0 + 1);
    tap(1'b1, 1'b0);
    fire_btn = 1'b1;
    repeat (8) tick();
    fire_btn = 1'b0;
    charge_busy = 1'b1;
    tick();
    charge_busy = 1'b0;
    tick();
    check_eq("arst_cool_enter", 32'(state_o), 4);
    repeat (5) tick();
    check_eq("arst_cool5", 32'(cooldown), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_cool_state", 32'(state_o), 0);
    check_eq("arst_cool_out", 32'(cooldown), 0);
    check_eq("arst_cool_armed", 32'(armed), 0);
    check_eq("arst_cool_fault", 32'(fault), 0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("arst_after_state", 32'(state_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
